// File: rtl/byte_mem_pkg.sv
// Shared constants for byte_mem_responder: IO window select, register offsets,
// status bit positions and the IO address decoder.
package byte_mem_pkg;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [31:0] IO_DATA = 32'h0003_0000;
    localparam logic [31:0] IO_STAT = 32'h0003_0004;

    localparam int STAT_RX_AVAIL = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_OVF      = 2;

    typedef enum logic [1:0] {
        IO_NONE,
        IO_REG_DATA,
        IO_REG_STAT,
        IO_REG_OTHER
    } io_reg_e;

    function automatic io_reg_e decode_io(input logic [31:0] addr);
        io_reg_e sel;
        if (addr[17:16] != IO_SEL)  sel = IO_NONE;
        else if (addr == IO_DATA)   sel = IO_REG_DATA;
        else if (addr == IO_STAT)   sel = IO_REG_STAT;
        else                        sel = IO_REG_OTHER;
        return sel;
    endfunction

endpackage

// File: rtl/byte_mem_responder_byte_fifo.sv
// byte_fifo: power-of-two byte FIFO with a show-ahead head, synchronous
// active-high reset, every state change gated by rdy.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  push,
    input  logic [7:0]            push_data,
    input  logic                  pop,
    output logic [7:0]            head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  do_push;
    logic                  do_pop;

    // Full is judged on the pre-pop count, so a push into a full FIFO is
    // dropped even when a pop frees a slot on the same edge.
    assign full    = (count_reg == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = rdy && push && !full;
    assign do_pop  = rdy && pop && !empty;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

endmodule

// File: rtl/byte_mem_responder.sv
// Responder for the CPU byte-wide memory bus: 1-cycle registered RAM reads,
// plus an optional IO window (TX FIFO, RX holding register, halt) under BYTE_MEM_IO_MAP_EN.
module byte_mem_responder
    import byte_mem_pkg::*;
#(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt
);

    logic [7:0]            ram [0:(1 << ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] idx;
    logic [7:0]            mem_din_reg;
    logic                  io_hit;
    logic [7:0]            io_rdata;

    assign idx     = mem_a[ADDR_WIDTH-1:0];
    assign mem_din = mem_din_reg;

`ifdef BYTE_MEM_IO_MAP_EN
    io_reg_e              io_sel;
    logic                 tx_push;
    logic                 tx_full;
    logic                 tx_empty;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic                 ovf_reg;
    logic                 rx_avail_reg;
    logic [7:0]           rx_hold_reg;
    logic                 halt_reg;
    logic                 rd_data_io;
    logic                 rd_stat_io;
    logic [7:0]           status;
    logic                 unused_bits;

    assign io_sel     = decode_io(mem_a);
    assign io_hit     = (io_sel != IO_NONE);
    assign tx_push    = mem_wr && (io_sel == IO_REG_DATA);
    assign rd_data_io = rdy && !mem_wr && (io_sel == IO_REG_DATA);
    assign rd_stat_io = rdy && !mem_wr && (io_sel == IO_REG_STAT);
    assign unused_bits = ^{mem_a[31:18], tx_count};

    byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .push      (tx_push),
        .push_data (mem_dout),
        .pop       (tx_ready && !tx_empty),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_avail_reg;
    assign halt     = halt_reg;

    always_comb begin
        status                = '0;
        status[STAT_RX_AVAIL] = rx_avail_reg;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_OVF]      = ovf_reg;
    end

    always_comb begin
        io_rdata = 8'h00;
        case (io_sel)
            IO_REG_DATA: io_rdata = rx_avail_reg ? rx_hold_reg : 8'h00;
            IO_REG_STAT: io_rdata = status;
            default:     io_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg      <= 1'b0;
            rx_avail_reg <= 1'b0;
            rx_hold_reg  <= 8'h00;
            halt_reg     <= 1'b0;
        end else if (rdy) begin
            halt_reg <= mem_wr && (io_sel == IO_REG_STAT);
            if (tx_push && tx_full)
                ovf_reg <= 1'b1;
            else if (rd_stat_io)
                ovf_reg <= 1'b0;
            // A load can only happen while empty, so it safely overrides the clear.
            if (rd_data_io)
                rx_avail_reg <= 1'b0;
            if (rx_valid && !rx_avail_reg) begin
                rx_hold_reg  <= rx_data;
                rx_avail_reg <= 1'b1;
            end
        end
    end
`else
    logic unused_bits;

    assign io_hit      = 1'b0;
    assign io_rdata    = 8'h00;
    assign tx_data     = 8'h00;
    assign tx_valid    = 1'b0;
    assign rx_ready    = 1'b0;
    assign halt        = 1'b0;
    assign unused_bits = ^{mem_a[31:ADDR_WIDTH], tx_ready, rx_data, rx_valid};
`endif

    always_ff @(posedge clk) begin
        if (rdy && mem_wr && !io_hit) ram[idx] <= mem_dout;
    end

    // Read-before-write: a write cycle still returns the old byte.
    always_ff @(posedge clk) begin
        if (rst)
            mem_din_reg <= 8'h00;
        else if (rdy)
            mem_din_reg <= io_hit ? io_rdata : ram[idx];
    end

endmodule

// File: doc/byte_mem_responder.md
# byte_mem_responder

Responder end of the CPU byte-wide memory bus. It sits opposite the CPU memory accesser and answers its `mem_a`/`mem_wr`/`mem_dout` requests with a registered 1-cycle read, backed by an on-chip byte RAM. Optionally it decodes a small memory-mapped I/O window with a transmit FIFO, a receive holding register and a halt strobe.

## Interface
- `ADDR_WIDTH`, default 17: RAM holds 2^ADDR_WIDTH bytes, indexed by `mem_a[ADDR_WIDTH-1:0]`.
- `TX_DEPTH_LOG2`, default 3: TX FIFO depth is 2^TX_DEPTH_LOG2 bytes.
- `clk` input 1: single clock; all logic on posedge.
- `rst` input 1: reset is synchronous and active-high.
- `rdy` input 1: global enable; when low, no state changes and all outputs hold.
- `mem_a` input 32: byte address from the initiator.
- `mem_wr` input 1: 1 = write `mem_dout` at `mem_a`; 0 = read.
- `mem_dout` input 8: write data from the initiator.
- `mem_din` output 8: registered read data to the initiator.
- `tx_data` output 8: head of the TX FIFO.
- `tx_valid` output 1: FIFO non-empty.
- `tx_ready` input 1: sink accepts `tx_data` this cycle.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: holding register empty, so a byte can be loaded.
- `halt` output 1: one-cycle program-end strobe.

## Operation
- Every `rdy` cycle, both the request and the data are sampled at posedge. There is no request valid: a read is implied whenever `mem_wr`=0.
- RAM read: `mem_din <= ram[mem_a[ADDR_WIDTH-1:0]]`.
- RAM write: `ram[idx] <= mem_dout`. `mem_din` still updates with the old byte (read-before-write).
- IO window (macro enabled): `mem_a[17:16]==2'b11`. It takes precedence over RAM, and RAM is untouched on IO accesses.
  - Write 0x30000: push `mem_dout` into TX FIFO. If the FIFO is full, drop the byte and set sticky `ovf`.
  - Write 0x30004: pulse `halt` for 1 cycle.
  - Read 0x30000: return the holding byte and clear `rx_avail`. If `rx_avail`=0, return 0x00.
  - Read 0x30004: return `{5'b0, ovf, tx_full, rx_avail}`. This read clears `ovf`.
  - Any other IO address: reads return 0x00, writes are ignored.
- RX: when `rx_valid && rx_ready`, load the holding register and set `rx_avail`. `rx_ready = ~rx_avail`.
- TX: pop the FIFO when `tx_valid && tx_ready`.
- Reset values:
  - `mem_din`=0x00, `halt`=0, `tx_valid`=0, `rx_ready`=1.
  - FIFO pointers/count=0, `ovf`=0, `rx_avail`=0.
  - RAM contents are not reset.

## Timing
- Read latency: the address is driven by the initiator after edge N and the responder latches it at edge N+1. `mem_din` is valid for the initiator to sample at edge N+2. Back-to-back addresses stream one byte per cycle.
- Write: takes effect at the sampling edge. A read of the same address on the next cycle returns the new byte.
- FIFO full check uses the pre-pop count. A push to a full FIFO is dropped even if a pop occurs in the same cycle.
- Push to an empty FIFO: `tx_valid` rises the cycle after the push edge.
- Simultaneous push and pop when neither full nor empty: the count is unchanged.
- Pointers wrap modulo 2^TX_DEPTH_LOG2. The count is TX_DEPTH_LOG2+1 bits wide.
- `rdy`=0: the request is ignored, and FIFO, RX and `halt` hold. `halt` must not repeat: it is cleared on the next `rdy` cycle.
- Reset mid-stream: the FIFO is emptied, queued bytes are lost, and `mem_din`=0 on the next cycle.

## Configuration
- `BYTE_MEM_IO_MAP_EN` defined: the IO window, TX FIFO, RX holding register and `halt` are present as described.
- `BYTE_MEM_IO_MAP_EN` undefined: every address maps to RAM. `tx_valid`=0, `tx_data`=0x00, `rx_ready`=0 and `halt`=0 are tied off, and no FIFO logic is instantiated.

## Structure
- The shared defines/package holds:
  - `IO_SEL` = 2'b11 (decoded on `mem_a[17:16]`).
  - IO offsets `IO_DATA` = 0x30000 and `IO_STAT` = 0x30004.
  - The status bit indices.
- One sub-module, `byte_fifo`: parameterised depth, push/pop/full/empty/count, synchronous active-high `rst`, gated by `rdy`.

## Test plan
- Write 0x12 @0x00010, then read 0x00010 → `mem_din`=0x12 exactly two edges after the read address is driven.
- Stream reads 0x00100..0x00103 preloaded with 11,22,33,44 → `mem_din` shows 11,22,33,44 on consecutive cycles.
- With `tx_ready`=0, write 9 bytes to 0x30000 (depth 8) → 8 bytes queued, 9th dropped. A status read returns 0x06, and a repeat status read returns 0x02 once `ovf` clears. Drain order is the first 8 bytes.
- Drive `rx_data`=0x5A with `rx_valid`=1 → `rx_ready` falls. Status bit0=1. Read 0x30000 returns 0x5A, `rx_ready` returns to 1, and a second read returns 0x00.
- Write 0x30004 with `rdy` toggling → exactly one `halt` pulse. Assert `rst` while 3 bytes are queued → `tx_valid`=0 and `mem_din`=0x00 the next cycle.
- Build with `BYTE_MEM_IO_MAP_EN` undefined → write 0xAB @0x30000 and read it back as 0xAB. `tx_valid` stays 0.
